// File: rtl/meter_pkg.sv
// Shared constants, mode encoding and helpers for the parking meter controller.
package meter_pkg;

  localparam int unsigned TIME_W = 14;
  localparam int unsigned BCD_W  = 16;

  localparam logic [13:0] MAX_TIME   = 14'd9999;
  localparam logic [13:0] LOW_THRESH = 14'd180;

  // Add amounts carry one extra bit so the sum can exceed MAX_TIME before clamping.
  localparam logic [14:0] ADD0 = 15'd60;
  localparam logic [14:0] ADD1 = 15'd120;
  localparam logic [14:0] ADD2 = 15'd180;
  localparam logic [14:0] ADD3 = 15'd300;

  localparam logic [13:0] PRESET_A = 14'd10;
  localparam logic [13:0] PRESET_B = 14'd205;

  typedef enum logic [1:0] {
    MODE_EXPIRED = 2'b00,
    MODE_LOW     = 2'b01,
    MODE_NORMAL  = 2'b10
  } mode_e;

  // Classify a remaining-time value into its display mode.
  function automatic mode_e mode_of(input logic [13:0] t);
    mode_e m;
    if (t == 14'd0) begin
      m = MODE_EXPIRED;
    end else if (t < LOW_THRESH) begin
      m = MODE_LOW;
    end else begin
      m = MODE_NORMAL;
    end
    return m;
  endfunction

endpackage

// File: rtl/meter_ctrl_bin2bcd.sv
// Combinational double-dabble converter: 14-bit binary to 4 BCD digits.
module bin2bcd
  import meter_pkg::*;
(
  input  logic [TIME_W-1:0] bin,
  output logic [BCD_W-1:0]  bcd
);

  logic [29:0] sh_s;

  // Shift-and-add-3: correct each digit that would overflow before every shift.
  always_comb begin
    sh_s = {16'd0, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh_s[14 + 4*d +: 4] >= 4'd5) begin
          sh_s[14 + 4*d +: 4] = sh_s[14 + 4*d +: 4] + 4'd3;
        end else begin
          sh_s[14 + 4*d +: 4] = sh_s[14 + 4*d +: 4];
        end
      end
      sh_s = {sh_s[28:0], 1'b0};
    end
    bcd = sh_s[29:14];
  end

endmodule

// File: rtl/meter_ctrl.sv
// Parking meter sequencing controller: remaining-time counter, mode FSM and blink control.
module meter_ctrl
  import meter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        tick_2hz,
  input  logic [3:0]  add_btn,
  input  logic [1:0]  preset,
  output logic [13:0] time_bin,
  output logic [15:0] time_bcd,
  output logic        disp_en,
  output logic [1:0]  mode
);

  logic [13:0] time_r;
  logic [15:0] bcd_r;
  logic        disp_r;
  logic        ph_r;
  mode_e       mode_r;

  logic [14:0] add_amt_s;
  logic [14:0] sum_s;
  logic [13:0] base_s;
  logic        tick_eff_s;
  logic [13:0] time_next_s;
  mode_e       mode_next_s;
  logic        ph_next_s;
  logic        disp_next_s;
  logic [15:0] bcd_s;

  bin2bcd u_bin2bcd (
    .bin (time_r),
    .bcd (bcd_s)
  );

  // Next remaining time: preset > add (lowest index) > hold, then saturate and tick down.
  always_comb begin
    add_amt_s = 15'd0;
    if (add_btn[0]) begin
      add_amt_s = ADD0;
    end else if (add_btn[1]) begin
      add_amt_s = ADD1;
    end else if (add_btn[2]) begin
      add_amt_s = ADD2;
    end else if (add_btn[3]) begin
      add_amt_s = ADD3;
    end else begin
      add_amt_s = 15'd0;
    end

    sum_s = {1'b0, time_r} + add_amt_s;

    if (preset[0]) begin
      base_s = PRESET_A;
    end else if (preset[1]) begin
      base_s = PRESET_B;
    end else if (sum_s > {1'b0, MAX_TIME}) begin
      base_s = MAX_TIME;
    end else begin
      base_s = sum_s[13:0];
    end

    // A preset load takes the exact preset value; the second tick is dropped.
    tick_eff_s = tick_1hz & ~(|preset);

    if (tick_eff_s && (base_s != 14'd0)) begin
      time_next_s = base_s - 14'd1;
    end else begin
      time_next_s = base_s;
    end
  end

  // Mode and blink phase for the next cycle, derived from the next time value.
  always_comb begin
    mode_next_s = mode_of(time_next_s);
    ph_next_s   = 1'b0;
    disp_next_s = 1'b1;
    if (mode_next_s != mode_r) begin
      ph_next_s = 1'b0;
    end else begin
      case (mode_next_s)
        MODE_LOW:     ph_next_s = tick_eff_s ? ~ph_r : ph_r;
        MODE_EXPIRED: ph_next_s = tick_2hz ? ~ph_r : ph_r;
        MODE_NORMAL:  ph_next_s = 1'b0;
        default:      ph_next_s = 1'b0;
      endcase
    end
    if (mode_next_s == MODE_NORMAL) begin
      disp_next_s = 1'b1;
    end else begin
      disp_next_s = ~ph_next_s;
    end
  end

  // State register for counter, mode, blink phase and display enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_r <= 14'd0;
      mode_r <= MODE_EXPIRED;
      ph_r   <= 1'b0;
      disp_r <= 1'b1;
    end else begin
      time_r <= time_next_s;
      mode_r <= mode_next_s;
      ph_r   <= ph_next_s;
      disp_r <= disp_next_s;
    end
  end

  // BCD output register, one cycle behind the binary counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_r <= 16'h0000;
    end else begin
      bcd_r <= bcd_s;
    end
  end

  assign time_bin = time_r;
  assign time_bcd = bcd_r;
  assign disp_en  = disp_r;
  assign mode     = mode_r;

endmodule

// File: tb/tb_meter_ctrl.sv
// Directed self-checking bench for meter_ctrl.
`timescale 1ns/1ps
module tb_meter_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1hz = 1'b0;
  logic        tick_2hz = 1'b0;
  logic [3:0]  add_btn = 4'd0;
  logic [1:0]  preset = 2'd0;
  logic [13:0] time_bin;
  logic [15:0] time_bcd;
  logic        disp_en;
  logic [1:0]  mode;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_d;

  meter_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .tick_2hz (tick_2hz),
    .add_btn  (add_btn),
    .preset   (preset),
    .time_bin (time_bin),
    .time_bcd (time_bcd),
    .disp_en  (disp_en),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of pulses, then release them.
  task automatic pulse(input logic [3:0] a, input logic [1:0] p, input logic t1, input logic t2);
    add_btn = a; preset = p; tick_1hz = t1; tick_2hz = t2;
    cyc();
    add_btn = 4'd0; preset = 2'd0; tick_1hz = 1'b0; tick_2hz = 1'b0;
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1;
    repeat (3) cyc();
    check_eq("rst_time", 32'(time_bin), 32'd0);
    check_eq("rst_bcd",  32'(time_bcd), 32'h0000);
    check_eq("rst_mode", 32'(mode), 32'd0);
    check_eq("rst_disp", 32'(disp_en), 32'd1);
    rst = 1'b0;
    exp_d = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse(4'd0, 2'd0, 1'b1, 1'b1);
      exp_d = ~exp_d;
      check_eq("idle_time", 32'(time_bin), 32'd0);
      check_eq("idle_disp", 32'(disp_en), 32'(exp_d));
    end

    // Add and decrement
    pulse(4'b0001, 2'd0, 1'b0, 1'b0);
    check_eq("add60_time", 32'(time_bin), 32'd60);
    check_eq("add60_mode", 32'(mode), 32'd1);
    check_eq("add60_disp", 32'(disp_en), 32'd1);
    cyc();
    check_eq("add60_bcd", 32'(time_bcd), 32'h0060);
    pulse(4'd0, 2'd0, 1'b1, 1'b1);
    check_eq("low_blink1", 32'(disp_en), 32'd0);
    pulse(4'd0, 2'd0, 1'b1, 1'b1);
    check_eq("low_blink2", 32'(disp_en), 32'd1);
    pulse(4'd0, 2'd0, 1'b1, 1'b1);
    check_eq("dec57_time", 32'(time_bin), 32'd57);
    check_eq("low_blink3", 32'(disp_en), 32'd0);
    cyc();
    check_eq("dec57_bcd", 32'(time_bcd), 32'h0057);

    // Saturation and simultaneous input
    pulse(4'd0, 2'b10, 1'b0, 1'b0);
    check_eq("presetB_time", 32'(time_bin), 32'd205);
    check_eq("presetB_mode", 32'(mode), 32'd2);
    for (int i = 0; i < 33; i++) pulse(4'b1000, 2'd0, 1'b0, 1'b0);
    check_eq("sat_time", 32'(time_bin), 32'd9999);
    cyc();
    check_eq("sat_bcd", 32'(time_bcd), 32'h9999);
    pulse(4'b1000, 2'd0, 1'b1, 1'b1);
    check_eq("sat_tick", 32'(time_bin), 32'd9998);
    pulse(4'b1010, 2'd0, 1'b0, 1'b0);
    check_eq("add_prio", 32'(time_bin), 32'd9999);

    // Threshold crossing
    pulse(4'd0, 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) pulse(4'd0, 2'd0, 1'b1, 1'b1);
    check_eq("thr_time", 32'(time_bin), 32'd180);
    check_eq("thr_mode", 32'(mode), 32'd2);
    check_eq("thr_disp", 32'(disp_en), 32'd1);
    pulse(4'd0, 2'd0, 1'b1, 1'b1);
    check_eq("t179_time", 32'(time_bin), 32'd179);
    check_eq("t179_mode", 32'(mode), 32'd1);
    check_eq("t179_disp", 32'(disp_en), 32'd1);
    pulse(4'd0, 2'd0, 1'b1, 1'b1);
    check_eq("t178_disp", 32'(disp_en), 32'd0);
    cyc();
    check_eq("t178_bcd", 32'(time_bcd), 32'h0178);

    // Expiry
    pulse(4'd0, 2'b01, 1'b0, 1'b0);
    check_eq("presetA_time", 32'(time_bin), 32'd10);
    check_eq("presetA_mode", 32'(mode), 32'd1);
    for (int i = 0; i < 10; i++) pulse(4'd0, 2'd0, 1'b1, 1'b1);
    check_eq("exp_time", 32'(time_bin), 32'd0);
    check_eq("exp_mode", 32'(mode), 32'd0);
    check_eq("exp_disp", 32'(disp_en), 32'd1);
    pulse(4'd0, 2'd0, 1'b1, 1'b1);
    check_eq("exp11_time", 32'(time_bin), 32'd0);
    check_eq("exp11_disp", 32'(disp_en), 32'd0);
    pulse(4'd0, 2'd0, 1'b0, 1'b1);
    check_eq("exp_2hz_a", 32'(disp_en), 32'd1);
    pulse(4'd0, 2'd0, 1'b0, 1'b1);
    check_eq("exp_2hz_b", 32'(disp_en), 32'd0);

    // Expired straight to normal on +300
    pulse(4'b1000, 2'd0, 1'b0, 1'b0);
    check_eq("e2n_time", 32'(time_bin), 32'd300);
    check_eq("e2n_mode", 32'(mode), 32'd2);
    cyc();
    check_eq("e2n_bcd", 32'(time_bcd), 32'h0300);

    // Priority and reset
    pulse(4'b0001, 2'b11, 1'b1, 1'b1);
    check_eq("prio_preset", 32'(time_bin), 32'd10);
    rst = 1'b1;
    pulse(4'b1000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    check_eq("rst_mid_time", 32'(time_bin), 32'd0);
    check_eq("rst_mid_mode", 32'(mode), 32'd0);
    check_eq("rst_mid_disp", 32'(disp_en), 32'd1);
    check_eq("rst_mid_bcd", 32'(time_bcd), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
